mix_columns: RTL and testbench



---
 rtl/aes_pkg.sv | 18 +
 rtl/mix_single_column.sv | 21 ++
 rtl/mix_columns.sv | 40 ++++
 tb/tb_mix_columns.sv | 111 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  // Multiply by 2 modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column; row 0 is the top byte.
module mix_single_column
  import aes_pkg::*;
(
  input  aes_word_t col_in,
  output aes_word_t col_out
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col_in[31:24];
  assign s1 = col_in[23:16];
  assign s2 = col_in[15:8];
  assign s3 = col_in[7:0];

  assign col_out[31:24] = gf_xtime(s0) ^ gf_mul3(s1) ^ s2 ^ s3;
  assign col_out[23:16] = s0 ^ gf_xtime(s1) ^ gf_mul3(s2) ^ s3;
  assign col_out[15:8]  = s0 ^ s1 ^ gf_xtime(s2) ^ gf_mul3(s3);
  assign col_out[7:0]   = gf_mul3(s0) ^ s1 ^ s2 ^ gf_xtime(s3);

endmodule

// File: rtl/mix_columns.sv
// Registered AES MixColumns stage with bypass for the final round.
module mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] dataIn,
  output logic [127:0] dataOut
);

  aes_state_t mixed;
  aes_state_t data_d;
  aes_state_t data_q;

  for (genvar c = 0; c < 4; c++) begin : g_col
    mix_single_column u_col (
      .col_in  (dataIn[127-32*c -: 32]),
      .col_out (mixed[127-32*c -: 32])
    );
  end

  always_comb begin
    data_d = dataIn;
    if (enable) begin
      data_d = mixed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dataOut = data_q;

endmodule

// File: tb/tb_mix_columns.sv
// Directed self-checking bench for mix_columns using known AES column vectors.
module tb_mix_columns;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [127:0] dataIn;
  logic [127:0] dataOut;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] FipsIn  = 128'hDB135345F20A225C01010101C6C6C6C6;
  localparam logic [127:0] FipsOut = 128'h8E4DA1BC9FDC589D01010101C6C6C6C6;
  localparam logic [127:0] R1In    = 128'hA2B87EB552B63484AC44CBEFEB507F31;
  localparam logic [127:0] R1Out   = 128'h47FE224AD5FD1B67AB8D4FA573FB166B;
  localparam logic [127:0] R2In    = 128'hCA6E80D7A0543F0EC358558977895ED9;
  localparam logic [127:0] R2Out   = 128'h6A5ADD1E9647988CA905B15AE94532E7;

  mix_columns dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .dataIn  (dataIn),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] expected);
    checks++;
    assert (dataOut === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, dataOut, expected);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    dataIn = FipsIn;
    step();
    check("reset_state", 128'h0);

    rst = 1'b0;
    step();
    check("fips_columns", FipsOut);

    // Output must not follow input between edges.
    dataIn = R1In;
    #2;
    check("hold_between_edges", FipsOut);

    step();
    check("round1", R1Out);
    dataIn = R2In;
    step();
    check("round2_back_to_back", R2Out);

    enable = 1'b0;
    step();
    check("bypass", R2In);

    enable = 1'b1;
    step();
    check("toggle_en1", R2Out);
    enable = 1'b0;
    step();
    check("toggle_en0", R2In);
    enable = 1'b1;
    step();
    check("toggle_en1_again", R2Out);

    dataIn = R1In;
    step();
    check("load_before_reset", R1Out);
    rst = 1'b1;
    step();
    check("reset_mid_stream", 128'h0);
    rst    = 1'b0;
    dataIn = FipsIn;
    step();
    check("after_reset_release", FipsOut);

    dataIn = 128'h0;
    step();
    check("all_zero", 128'h0);
    dataIn = {16{8'h01}};
    step();
    check("all_01", {16{8'h01}});
    dataIn = {16{8'hFF}};
    step();
    check("all_ff", {16{8'hFF}});

    enable = 1'b0;
    dataIn = FipsIn;
    step();
    check("bypass_fips", FipsIn);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
